// File: rtl/bsg_trace_pkg.sv
// Shared types for the multi-channel trace replayer: trace ops, engine states
// and the channel-field width helper.
package bsg_trace_pkg;

  localparam int trace_op_width_gp = 4;

  // Op and state enumerators share one namespace, so ops carry an eOP_ prefix.
  typedef enum logic [3:0] {
    eOP_NOP     = 4'd0,
    eOP_SEND    = 4'd1,
    eOP_RECV    = 4'd2,
    eOP_SETMASK = 4'd3,
    eOP_DELAY   = 4'd4,
    eOP_DONE    = 4'd5
  } trace_op_e;

  typedef enum logic [1:0] {
    eRUN   = 2'd0,
    eDELAY = 2'd1,
    eDONE  = 2'd2
  } trace_state_e;

  function automatic int trace_ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_trace_decode.sv
// Combinational split of a trace entry into op/payload, with a legality flag
// and a one-hot select of the addressed channel (all zero when illegal).
module bsg_trace_decode
  import bsg_trace_pkg::*;
#(
  parameter  int ring_width_p   = 8,
  parameter  int num_channels_p = 1,
  localparam int ch_w_lp        = trace_ch_width(num_channels_p),
  localparam int trace_width_lp = trace_op_width_gp + ch_w_lp + ring_width_p
) (
  input  logic [trace_width_lp-1:0]    entry_i,
  output logic [trace_op_width_gp-1:0] op_o,
  output logic [ring_width_p-1:0]      payload_o,
  output logic                         legal_o,
  output logic [num_channels_p-1:0]    ch_one_hot_o
);

  logic [ch_w_lp-1:0] ch;

  assign {op_o, ch, payload_o} = entry_i;
  assign legal_o = (op_o <= eOP_DONE) && (32'(ch) < num_channels_p);

  always_comb begin
    ch_one_hot_o = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (legal_o && (ch == ch_w_lp'(c))) ch_one_hot_o[c] = 1'b1;
    end
  end

endmodule

// File: rtl/bsg_trace_replay_multi.sv
// Multi-channel trace replayer: one engine walks a trace ROM and drives
// per-channel SEND/RECV handshakes. Optional stall watchdog: BSG_TRACE_REPLAY_WATCHDOG_EN.
module bsg_trace_replay_multi
  import bsg_trace_pkg::*;
#(
  parameter  int ring_width_p      = 8,
  parameter  int num_channels_p    = 1,
  parameter  int rom_addr_width_p  = 32,
  parameter  int err_count_width_p = 16,
  parameter  int timeout_p         = 1024,
  localparam int ch_w_lp           = trace_ch_width(num_channels_p),
  localparam int trace_width_lp    = trace_op_width_gp + ch_w_lp + ring_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   en_i,
  input  logic [num_channels_p-1:0]              v_i,
  input  logic [num_channels_p*ring_width_p-1:0] data_i,
  output logic [num_channels_p-1:0]              ready_o,
  output logic [num_channels_p-1:0]              v_o,
  output logic [ring_width_p-1:0]                data_o,
  input  logic [num_channels_p-1:0]              yumi_i,
  output logic [rom_addr_width_p-1:0]            rom_addr_o,
  input  logic [trace_width_lp-1:0]              rom_data_i,
  output logic                                   done_o,
  output logic                                   error_o,
  output logic [err_count_width_p-1:0]           err_count_o,
  output trace_state_e                           state_o
);

  // Handshakes: input side transfers when ready_o[c] & v_i[c]; output side
  // transfers when v_o[c] & yumi_i[c]. yumi_i is late (same cycle as v_o), so
  // v_o never depends on yumi_i. Only the addressed channel is ever asserted.

  trace_state_e                     state_r, state_n;
  logic [rom_addr_width_p-1:0]      addr_r, addr_n;
  logic [ring_width_p-1:0]          delay_r, delay_n;
  logic [ring_width_p-1:0]          mask_r, mask_n;
  logic [err_count_width_p-1:0]     err_cnt_r, err_cnt_n;
  logic                             error_r, error_n;
  logic                             inc_err;

  logic [trace_op_width_gp-1:0]     op;
  logic [ring_width_p-1:0]          payload;
  logic                             legal;
  logic [num_channels_p-1:0]        ch_oh;
  logic                             sel_v, sel_yumi, mismatch;
  logic [ring_width_p-1:0]          sel_data;

  bsg_trace_decode #(
    .ring_width_p  (ring_width_p),
    .num_channels_p(num_channels_p)
  ) decode (
    .entry_i     (rom_data_i),
    .op_o        (op),
    .payload_o   (payload),
    .legal_o     (legal),
    .ch_one_hot_o(ch_oh)
  );

  assign sel_v    = |(v_i & ch_oh);
  assign sel_yumi = |(yumi_i & ch_oh);

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (ch_oh[c]) sel_data = data_i[c*ring_width_p +: ring_width_p];
    end
  end

  assign mismatch = (sel_data & mask_r) != (payload & mask_r);

`ifdef BSG_TRACE_REPLAY_WATCHDOG_EN
  localparam int stall_w_lp = $clog2(timeout_p + 1);
  logic [stall_w_lp-1:0] stall_r, stall_n;
  logic                  stalled, wd_trip;

  assign stalled = en_i && (state_r == eRUN) && legal &&
                   (((op == eOP_SEND) && !sel_yumi) || ((op == eOP_RECV) && !sel_v));
  assign wd_trip = stalled && (stall_r == stall_w_lp'(timeout_p - 1));

  always_comb begin
    stall_n = stall_r;
    if (en_i) stall_n = stalled ? stall_r + stall_w_lp'(1) : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stall_r <= '0;
    else            stall_r <= stall_n;
  end
`endif

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= eRUN;
      addr_r    <= '0;
      delay_r   <= '0;
      mask_r    <= '1;
      err_cnt_r <= '0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      addr_r    <= addr_n;
      delay_r   <= delay_n;
      mask_r    <= mask_n;
      err_cnt_r <= err_cnt_n;
      error_r   <= error_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    addr_n  = addr_r;
    delay_n = delay_r;
    mask_n  = mask_r;
    inc_err = 1'b0;
    if (en_i) begin
      case (state_r)
        eRUN: begin
          if (!legal) begin
            inc_err = 1'b1;
            addr_n  = addr_r + rom_addr_width_p'(1);
          end else begin
            case (op)
              eOP_NOP: addr_n = addr_r + rom_addr_width_p'(1);
              eOP_SEND: begin
                if (sel_yumi) addr_n = addr_r + rom_addr_width_p'(1);
              end
              eOP_RECV: begin
                if (sel_v) begin
                  inc_err = mismatch;
                  addr_n  = addr_r + rom_addr_width_p'(1);
                end
              end
              eOP_SETMASK: begin
                mask_n = payload;
                addr_n = addr_r + rom_addr_width_p'(1);
              end
              eOP_DELAY: begin
                addr_n = addr_r + rom_addr_width_p'(1);
                if (payload != '0) begin
                  delay_n = payload - ring_width_p'(1);
                  state_n = eDELAY;
                end
              end
              eOP_DONE: state_n = eDONE;
              default: ;
            endcase
`ifdef BSG_TRACE_REPLAY_WATCHDOG_EN
            if (wd_trip) begin
              inc_err = 1'b1;
              state_n = eDONE;
            end
`endif
          end
        end
        eDELAY: begin
          if (delay_r == '0) state_n = eRUN;
          else               delay_n = delay_r - ring_width_p'(1);
        end
        default: ;
      endcase
    end
    error_n   = error_r | inc_err;
    err_cnt_n = (inc_err && !(&err_cnt_r)) ? err_cnt_r + err_count_width_p'(1) : err_cnt_r;
  end

  // Outputs: handshakes decoded from state and op; reset gates them at once.
  always_comb begin
    v_o     = '0;
    ready_o = '0;
    data_o  = '0;
    if (reset_n_i && en_i && (state_r == eRUN) && legal) begin
      if (op == eOP_SEND) begin
        v_o    = ch_oh;
        data_o = payload;
      end else if (op == eOP_RECV) begin
        ready_o = ch_oh;
      end
    end
  end

  assign done_o      = (state_r == eDONE);
  assign error_o     = error_r;
  assign err_count_o = err_cnt_r;
  assign rom_addr_o  = addr_r;
  assign state_o     = state_r;

endmodule
